// File: rtl/instruction_decode_stage_pkg.sv
// Shared types and constants for the instruction decode stage.
package instruction_decode_stage_pkg;

  typedef enum logic [1:0] {
    FMT_A    = 2'd0,
    FMT_B    = 2'd1,
    FMT_C    = 2'd2,
    FMT_NONE = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    Q_EMPTY,
    Q_PARTIAL,
    Q_FULL
  } qstate_e;

  localparam logic [5:0] OP_ALU  = 6'b000000;
  localparam logic [5:0] OP_IMM0 = 6'b100010;
  localparam logic [5:0] OP_IMM1 = 6'b100011;
  localparam logic [5:0] OP_JMP0 = 6'b000010;
  localparam logic [5:0] OP_JMP1 = 6'b000011;
  localparam logic [5:0] OP_NOP  = 6'b111111;

  localparam int unsigned OPC_W = 17;

  // Width-independent part of a decoded entry; register fields and the
  // immediate are stored alongside it at their parameterised widths.
  typedef struct packed {
    fmt_e             fmt;
    logic             nop;
    logic             ifnr;
    logic [OPC_W-1:0] opcode;
  } decoded_ctrl_t;

endpackage

// File: rtl/instruction_decode_stage_decode_fields.sv
// Pure combinational split of one instruction word into decoded fields.
module decode_fields
  import instruction_decode_stage_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_extend,
  output logic [REG_W-1:0]   o_rs1,
  output logic [REG_W-1:0]   o_rs2,
  output logic [REG_W-1:0]   o_rd,
  output logic [DATA_W-1:0]  o_imm,
  output decoded_ctrl_t      o_ctrl
);

  logic [15:0] w_f16;
  logic [25:0] w_f26;
  logic [5:0]  w_op;

  assign w_f16 = i_instr[21:6];
  assign w_f26 = i_instr[31:6];
  assign w_op  = i_instr[5:0];

  // Classify on the low opcode bits and extract the matching field layout.
  always_comb begin
    o_rs1         = '0;
    o_rs2         = '0;
    o_rd          = '0;
    o_imm         = '0;
    o_ctrl        = '0;
    o_ctrl.fmt    = FMT_NONE;
    unique case (w_op)
      OP_ALU: begin
        o_ctrl.fmt    = FMT_A;
        o_rs1         = REG_W'(i_instr[31:27]);
        o_rs2         = REG_W'(i_instr[26:22]);
        o_rd          = REG_W'(i_instr[21:17]);
        o_ctrl.opcode = i_instr[16:0];
      end
      OP_IMM0, OP_IMM1: begin
        o_ctrl.fmt    = FMT_B;
        o_rs1         = REG_W'(i_instr[31:27]);
        o_rd          = REG_W'(i_instr[26:22]);
        o_ctrl.opcode = OPC_W'(w_op);
        o_imm         = i_extend ? DATA_W'($signed(w_f16)) : DATA_W'(w_f16);
      end
      OP_JMP0, OP_JMP1: begin
        o_ctrl.fmt    = FMT_C;
        o_ctrl.opcode = OPC_W'(w_op);
        o_imm         = i_extend ? DATA_W'($signed(w_f26)) : DATA_W'(w_f26);
      end
      OP_NOP: begin
        o_ctrl.nop = 1'b1;
      end
      default: begin
        o_ctrl.ifnr = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// Flow-controlled decode stage: decodes each accepted word and buffers the
// result in a small circular queue whose head drives the outputs.
module instruction_decode_stage
  import instruction_decode_stage_pkg::*;
#(
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 2,
  parameter bit          DROP_NOP = 1'b0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [INSTR_W-1:0]       Instruction,
  input  logic                     Extend,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [REG_W-1:0]         Rsrc1,
  output logic [REG_W-1:0]         Rsrc2,
  output logic [REG_W-1:0]         Rdst,
  output logic [16:0]              OP_Code,
  output logic [DATA_W-1:0]        IMMEDIATE_Decoded,
  output logic [1:0]               InstructionFormat,
  output logic                     NOP_FLAG,
  output logic                     IFNR_FLAG,
  output logic [$clog2(DEPTH):0]   Occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [REG_W-1:0]  w_rs1, w_rs2, w_rd;
  logic [DATA_W-1:0] w_imm;
  decoded_ctrl_t     w_ctrl;

  decode_fields #(
    .INSTR_W (INSTR_W),
    .REG_W   (REG_W),
    .DATA_W  (DATA_W)
  ) u_decode (
    .i_instr  (Instruction),
    .i_extend (Extend),
    .o_rs1    (w_rs1),
    .o_rs2    (w_rs2),
    .o_rd     (w_rd),
    .o_imm    (w_imm),
    .o_ctrl   (w_ctrl)
  );

  logic [REG_W-1:0]  r_rs1  [DEPTH];
  logic [REG_W-1:0]  r_rs2  [DEPTH];
  logic [REG_W-1:0]  r_rd   [DEPTH];
  logic [DATA_W-1:0] r_imm  [DEPTH];
  decoded_ctrl_t     r_ctrl [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;

  qstate_e w_qstate;
  logic    w_accept, w_push, w_pop;

  // Queue state is purely a view of the occupancy count.
  always_comb begin
    w_qstate = Q_PARTIAL;
    if (r_count == '0)
      w_qstate = Q_EMPTY;
    else if (r_count == CW'(DEPTH))
      w_qstate = Q_FULL;
  end

  // Reset forces the handshake outputs to their idle values immediately.
  assign InReady   = Reset || (w_qstate != Q_FULL);
  assign OutValid  = !Reset && (w_qstate != Q_EMPTY);
  assign Occupancy = Reset ? '0 : r_count;

  assign w_accept = InValid && InReady && !Reset;
  assign w_push   = w_accept && !(DROP_NOP && w_ctrl.nop);
  assign w_pop    = OutValid && OutReady;

  // Pointer and occupancy bookkeeping; data written at the tail on push.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_rs1[r_wr_ptr]  <= w_rs1;
        r_rs2[r_wr_ptr]  <= w_rs2;
        r_rd[r_wr_ptr]   <= w_rd;
        r_imm[r_wr_ptr]  <= w_imm;
        r_ctrl[r_wr_ptr] <= w_ctrl;
        r_wr_ptr         <= r_wr_ptr + AW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry to outputs, held at zero whenever nothing valid is presented.
  always_comb begin
    Rsrc1             = '0;
    Rsrc2             = '0;
    Rdst              = '0;
    OP_Code           = '0;
    IMMEDIATE_Decoded = '0;
    InstructionFormat = '0;
    NOP_FLAG          = 1'b0;
    IFNR_FLAG         = 1'b0;
    if (OutValid) begin
      Rsrc1             = r_rs1[r_rd_ptr];
      Rsrc2             = r_rs2[r_rd_ptr];
      Rdst              = r_rd[r_rd_ptr];
      OP_Code           = r_ctrl[r_rd_ptr].opcode;
      IMMEDIATE_Decoded = r_imm[r_rd_ptr];
      InstructionFormat = r_ctrl[r_rd_ptr].fmt;
      NOP_FLAG          = r_ctrl[r_rd_ptr].nop;
      IFNR_FLAG         = r_ctrl[r_rd_ptr].ifnr;
    end
  end

endmodule
